// File: rtl/core_pkg.sv
// Shared core types: instruction word, register index, opcode/format/rd-source
// enums and the decoded instruction record produced by the decode stage.
package core_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_index_t;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_UIMM  = 3'd6,
    FMT_OTHER = 3'd7
  } instr_format_e;

  typedef enum logic [1:0] {
    RD_FROM_ALU_RESULT  = 2'd0,
    RD_FROM_MEM_LOAD    = 2'd1,
    RD_FROM_NEXT_SEQ_PC = 2'd2,
    RD_FROM_CSR         = 2'd3
  } rd_src_e;

  typedef struct packed {
    word_t         pc;
    opcode_e       opcode;
    instr_format_e format;
    reg_index_t    rd;
    reg_index_t    rs1;
    reg_index_t    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    word_t         imm;
    rd_src_e       rd_src;
    logic          rd_we;
    logic          illegal;
  } decoded_instr_t;

endpackage

// File: rtl/core_decode_comb.sv
// Purely combinational RV32I field decode: format, immediate, destination
// source and write enable for one raw instruction word.
module core_decode_comb
  import core_pkg::*;
(
  input  word_t          i_instr,
  input  word_t          i_pc,
  output decoded_instr_t o_dec
);

  opcode_e       opcode;
  instr_format_e fmt;
  rd_src_e       rd_src;
  logic          rd_we;
  logic          illegal;
  word_t         imm;
  logic [2:0]    funct3;

  assign opcode = opcode_e'(i_instr[6:0]);
  assign funct3 = i_instr[14:12];

  always_comb begin
    fmt     = FMT_OTHER;
    rd_src  = RD_FROM_ALU_RESULT;
    rd_we   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:       begin fmt = FMT_R; rd_we = 1'b1; end
      OPC_LOAD:     begin fmt = FMT_I; rd_src = RD_FROM_MEM_LOAD; rd_we = 1'b1; end
      OPC_OP_IMM:   begin fmt = FMT_I; rd_we = 1'b1; end
      OPC_JALR:     begin fmt = FMT_I; rd_src = RD_FROM_NEXT_SEQ_PC; rd_we = 1'b1; end
      OPC_MISC_MEM: fmt = FMT_I;
      OPC_STORE:    fmt = FMT_S;
      OPC_BRANCH:   fmt = FMT_B;
      OPC_LUI:      begin fmt = FMT_U; rd_we = 1'b1; end
      OPC_AUIPC:    begin fmt = FMT_U; rd_we = 1'b1; end
      OPC_JAL:      begin fmt = FMT_J; rd_src = RD_FROM_NEXT_SEQ_PC; rd_we = 1'b1; end
      OPC_SYSTEM: begin
        fmt = funct3[2] ? FMT_UIMM : FMT_I;
        if (funct3 != 3'b000) begin
          rd_src = RD_FROM_CSR;
          rd_we  = 1'b1;
        end
      end
      default:      illegal = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11)
      illegal = 1'b1;
    if (illegal) begin
      fmt   = FMT_OTHER;
      rd_we = 1'b0;
    end
    // x0 is hardwired to zero, so never request a write to it
    if (i_instr[11:7] == 5'd0)
      rd_we = 1'b0;
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:    imm = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:    imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:    imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                       i_instr[11:8], 1'b0};
      FMT_U:    imm = {i_instr[31:12], 12'h000};
      FMT_J:    imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                       i_instr[30:21], 1'b0};
      FMT_UIMM: imm = {27'd0, i_instr[19:15]};
      default:  imm = '0;
    endcase
  end

  always_comb begin
    o_dec         = '0;
    o_dec.pc      = i_pc;
    o_dec.opcode  = opcode;
    o_dec.format  = fmt;
    o_dec.rd      = i_instr[11:7];
    o_dec.rs1     = i_instr[19:15];
    o_dec.rs2     = i_instr[24:20];
    o_dec.funct3  = funct3;
    o_dec.funct7  = i_instr[31:25];
    o_dec.imm     = imm;
    o_dec.rd_src  = rd_src;
    o_dec.rd_we   = rd_we;
    o_dec.illegal = illegal;
  end

endmodule

// File: rtl/core_decode.sv
// Decode stage: decodes the incoming word, then buffers it in a main + skid
// pair so fetch sees a registered ready and throughput stays one per cycle.
module core_decode
  import core_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_instr_valid,
  output logic           o_instr_ready,
  input  word_t          i_instr,
  input  word_t          i_pc,
  input  logic           i_flush,
  output logic           o_dec_valid,
  input  logic           i_dec_ready,
  output decoded_instr_t o_dec
);

  decoded_instr_t dec_new;
  decoded_instr_t main_q, main_d, skid_q, skid_d;
  logic           main_valid_q, main_valid_d;
  logic           skid_valid_q, skid_valid_d;
  logic           ready_q;
  logic           accept, consume;

  core_decode_comb u_comb (
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .o_dec   (dec_new)
  );

  // Skid is only ever filled while main is held, so the oldest entry is
  // always in main and order is preserved.
  always_comb begin
    accept       = i_instr_valid && ready_q;
    consume      = main_valid_q && i_dec_ready;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        if (accept)
          skid_d = dec_new;
        else
          skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec_new;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = dec_new;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec_new;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (i_flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign o_dec         = main_q;
  assign o_dec_valid   = main_valid_q;
  assign o_instr_ready = ready_q;

endmodule

// File: tb/tb_core_decode.sv
// Self-checking bench for core_decode: directed steps with a scoreboard of
// reference-decoded instructions compared in order on each output handshake.
module tb_core_decode;
  import core_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_instr_valid = 1'b0;
  logic           o_instr_ready;
  word_t          i_instr = '0;
  word_t          i_pc = '0;
  logic           i_flush = 1'b0;
  logic           o_dec_valid;
  logic           i_dec_ready = 1'b0;
  decoded_instr_t o_dec;

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;
  decoded_instr_t expQ[$];

  always #5 clk = ~clk;

  core_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .i_pc          (i_pc),
    .i_flush       (i_flush),
    .o_dec_valid   (o_dec_valid),
    .i_dec_ready   (i_dec_ready),
    .o_dec         (o_dec)
  );

  // Reference decoder keyed on raw opcode values
  function automatic decoded_instr_t refDecode(input word_t ins, input word_t pc);
    decoded_instr_t d;
    logic [12:0] bOff;
    logic [20:0] jOff;
    d = '0;
    d.pc = pc;
    d.opcode = opcode_e'(ins[6:0]);
    d.rd = ins[11:7];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.funct3 = ins[14:12];
    d.funct7 = ins[31:25];
    d.rd_src = RD_FROM_ALU_RESULT;
    case (ins[6:0])
      7'h33: begin d.format = FMT_R; d.rd_we = 1'b1; end
      7'h03: begin d.format = FMT_I; d.rd_src = RD_FROM_MEM_LOAD; d.rd_we = 1'b1; end
      7'h13: begin d.format = FMT_I; d.rd_we = 1'b1; end
      7'h67: begin d.format = FMT_I; d.rd_src = RD_FROM_NEXT_SEQ_PC; d.rd_we = 1'b1; end
      7'h0F: d.format = FMT_I;
      7'h23: d.format = FMT_S;
      7'h63: d.format = FMT_B;
      7'h37: begin d.format = FMT_U; d.rd_we = 1'b1; end
      7'h17: begin d.format = FMT_U; d.rd_we = 1'b1; end
      7'h6F: begin d.format = FMT_J; d.rd_src = RD_FROM_NEXT_SEQ_PC; d.rd_we = 1'b1; end
      7'h73: begin
        d.format = (ins[14] == 1'b1) ? FMT_UIMM : FMT_I;
        if (ins[14:12] != 3'b000) begin
          d.rd_src = RD_FROM_CSR;
          d.rd_we = 1'b1;
        end
      end
      default: begin d.format = FMT_OTHER; d.illegal = 1'b1; end
    endcase
    bOff = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jOff = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (d.format)
      FMT_I:    d.imm = {{20{ins[31]}}, ins[31:20]};
      FMT_S:    d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:    d.imm = {{19{bOff[12]}}, bOff};
      FMT_U:    d.imm = {ins[31:12], 12'h000};
      FMT_J:    d.imm = {{11{jOff[20]}}, jOff};
      FMT_UIMM: d.imm = {27'd0, ins[19:15]};
      default:  d.imm = '0;
    endcase
    if (d.rd == 5'd0) d.rd_we = 1'b0;
    return d;
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input word_t obs, input word_t exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input decoded_instr_t obs,
                             input decoded_instr_t exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; handshakes are judged just before the rising edge.
  task automatic applyStimulus(input logic valid, input word_t instr, input word_t pc,
                               input logic decReady, input logic flush);
    logic acc, cons;
    decoded_instr_t exp;
    i_instr_valid = valid;
    i_instr = instr;
    i_pc = pc;
    i_dec_ready = decReady;
    i_flush = flush;
    #1;
    acc = i_instr_valid && o_instr_ready;
    cons = o_dec_valid && i_dec_ready;
    if (!rst_n || flush) begin
      expQ.delete();
    end else begin
      if (cons) begin
        if (expQ.size() == 0) begin
          checkCount++;
          failCount++;
          $error("[TB] FAIL sb_underflow observed=%h expected=none", o_dec);
        end else begin
          exp = expQ.pop_front();
          checkOutput("sb_out", o_dec, exp);
        end
      end
      if (acc) expQ.push_back(refDecode(instr, pc));
    end
    @(posedge clk);
    #1;
  endtask

  localparam word_t ADDI_M1  = 32'hFFF00093;
  localparam word_t LUI_X10  = 32'h12345537;
  localparam word_t JAL_P8   = 32'h0080006F;
  localparam word_t CSRRWI   = 32'h3400D073;
  localparam word_t ADD_X3   = 32'h002081B3;
  localparam word_t SW_8     = 32'h0020A423;
  localparam word_t BEQ_M4   = 32'hFE208EE3;
  localparam word_t LW_M8    = 32'hFF812283;
  localparam word_t NOP      = 32'h00000013;

  word_t prog [12] = '{32'hFFF00093, 32'h12345537, 32'h0080006F, 32'h3400D073,
                       32'h002081B3, 32'h0020A423, 32'hFE208EE3, 32'hFF812283,
                       32'h407302B3, 32'h0FF0000F, 32'h300022F3, 32'h00004501};

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkBit("rst_valid", o_dec_valid, 1'b0);
    checkBit("rst_ready", o_instr_ready, 1'b1);
    checkOutput("rst_dec", o_dec, '0);
    rst_n = 1'b1;

    applyStimulus(1'b1, ADDI_M1, 32'h100, 1'b0, 1'b0);
    checkBit("addi_valid", o_dec_valid, 1'b1);
    checkWord("addi_fmt", 32'(o_dec.format), 32'(FMT_I));
    checkWord("addi_rd", 32'(o_dec.rd), 32'd1);
    checkWord("addi_rs1", 32'(o_dec.rs1), 32'd0);
    checkWord("addi_imm", o_dec.imm, 32'hFFFFFFFF);
    checkWord("addi_src", 32'(o_dec.rd_src), 32'(RD_FROM_ALU_RESULT));
    checkBit("addi_we", o_dec.rd_we, 1'b1);
    checkBit("addi_ready", o_instr_ready, 1'b1);

    applyStimulus(1'b1, LUI_X10, 32'h104, 1'b1, 1'b0);
    checkWord("lui_fmt", 32'(o_dec.format), 32'(FMT_U));
    checkWord("lui_rd", 32'(o_dec.rd), 32'd10);
    checkWord("lui_imm", o_dec.imm, 32'h12345000);
    checkBit("lui_we", o_dec.rd_we, 1'b1);

    applyStimulus(1'b1, JAL_P8, 32'h108, 1'b1, 1'b0);
    checkWord("jal_fmt", 32'(o_dec.format), 32'(FMT_J));
    checkWord("jal_imm", o_dec.imm, 32'd8);
    checkWord("jal_src", 32'(o_dec.rd_src), 32'(RD_FROM_NEXT_SEQ_PC));
    checkBit("jal_we", o_dec.rd_we, 1'b0);

    applyStimulus(1'b1, CSRRWI, 32'h10C, 1'b1, 1'b0);
    checkWord("csr_fmt", 32'(o_dec.format), 32'(FMT_UIMM));
    checkWord("csr_imm", o_dec.imm, 32'd1);
    checkWord("csr_src", 32'(o_dec.rd_src), 32'(RD_FROM_CSR));
    checkBit("csr_we", o_dec.rd_we, 1'b0);

    applyStimulus(1'b1, 32'h0, 32'h110, 1'b1, 1'b0);
    checkBit("zero_illegal", o_dec.illegal, 1'b1);
    checkWord("zero_fmt", 32'(o_dec.format), 32'(FMT_OTHER));
    checkWord("zero_imm", o_dec.imm, 32'd0);
    checkBit("zero_we", o_dec.rd_we, 1'b0);

    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkBit("drain_valid", o_dec_valid, 1'b0);

    // Backpressure: two accepted, third held off until downstream drains
    applyStimulus(1'b1, ADD_X3, 32'h200, 1'b0, 1'b0);
    checkBit("bp_ready1", o_instr_ready, 1'b1);
    applyStimulus(1'b1, SW_8, 32'h204, 1'b0, 1'b0);
    checkBit("bp_ready2", o_instr_ready, 1'b0);
    checkWord("bp_hold_pc1", o_dec.pc, 32'h200);
    applyStimulus(1'b1, BEQ_M4, 32'h208, 1'b0, 1'b0);
    checkWord("bp_hold_pc2", o_dec.pc, 32'h200);
    checkBit("bp_ready_held", o_instr_ready, 1'b0);
    applyStimulus(1'b1, BEQ_M4, 32'h208, 1'b1, 1'b0);
    checkWord("bp_pc_b", o_dec.pc, 32'h204);
    checkWord("sw_imm", o_dec.imm, 32'd8);
    checkBit("bp_ready3", o_instr_ready, 1'b1);
    applyStimulus(1'b1, BEQ_M4, 32'h208, 1'b1, 1'b0);
    checkWord("bp_pc_c", o_dec.pc, 32'h208);
    checkWord("beq_fmt", 32'(o_dec.format), 32'(FMT_B));
    checkWord("beq_imm", o_dec.imm, 32'hFFFFFFFC);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkBit("bp_empty", o_dec_valid, 1'b0);

    // Flush with both entries full and a new instruction offered
    applyStimulus(1'b1, LW_M8, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, ADD_X3, 32'h304, 1'b0, 1'b0);
    checkBit("fl_full_ready", o_instr_ready, 1'b0);
    applyStimulus(1'b1, SW_8, 32'h308, 1'b0, 1'b1);
    checkBit("fl_valid", o_dec_valid, 1'b0);
    checkBit("fl_ready", o_instr_ready, 1'b1);
    applyStimulus(1'b1, NOP, 32'h30C, 1'b0, 1'b0);
    checkBit("fl_next_valid", o_dec_valid, 1'b1);
    checkWord("fl_next_pc", o_dec.pc, 32'h30C);
    checkBit("nop_we_x0", o_dec.rd_we, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkBit("fl_empty", o_dec_valid, 1'b0);

    // Reset mid-operation with both entries full
    applyStimulus(1'b1, ADD_X3, 32'h400, 1'b0, 1'b0);
    applyStimulus(1'b1, SW_8, 32'h404, 1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkBit("mrst_valid", o_dec_valid, 1'b0);
    checkBit("mrst_ready", o_instr_ready, 1'b1);
    checkOutput("mrst_dec", o_dec, '0);
    rst_n = 1'b1;

    // Random traffic through the scoreboard
    for (int k = 0; k < 120; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, prog[$urandom_range(0, 11)],
                    32'h1000 + 32'(k * 4), $urandom_range(0, 2) != 0, 1'b0);
    end
    for (int k = 0; k < 20 && expQ.size() != 0; k++)
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkBit("sb_drained", expQ.size() == 0, 1'b1);
    checkBit("end_valid", o_dec_valid, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
